// File: rtl/karatsuba_pkg.sv
// Shared definitions for the sequential Karatsuba carry-less multiplier:
// FSM state encoding, default reduction polynomial and a bit-serial reference product.
package karatsuba_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    M_LO    = 3'd1,
    M_HI    = 3'd2,
    M_MID   = 3'd3,
    COMBINE = 3'd4,
    REDUCE  = 3'd5,
    DONE    = 3'd6
  } state_t;

  localparam logic [15:0] POLY_DEFAULT = 16'h100B;

  // Plain shift-and-xor product, up to 32x32 -> 64 bits.
  function automatic logic [63:0] clmul_ref(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] r;
    r = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (b[i]) r = r ^ ({32'd0, a} << i);
    end
    return r;
  endfunction

endpackage

// File: rtl/karatsuba_clmul_comb.sv
// Recursive combinational Karatsuba carry-less multiplier, W x W -> 2W bits.
// Bottoms out at the 2-bit cell; the top product bit is always zero.
module karatsuba_clmul_comb #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0]   i_a,
  input  logic [W-1:0]   i_b,
  output logic [2*W-1:0] o_p
);

  if (W == 2) begin : g_leaf
    logic w_p0, w_p1, w_p2;
    assign w_p0 = i_a[0] & i_b[0];
    assign w_p2 = i_a[1] & i_b[1];
    assign w_p1 = ((i_a[0] ^ i_a[1]) & (i_b[0] ^ i_b[1])) ^ w_p0 ^ w_p2;
    assign o_p  = {1'b0, w_p2, w_p1, w_p0};
  end else begin : g_split
    localparam int unsigned H = W / 2;
    logic [W-1:0] w_l, w_h, w_m;

    karatsuba_clmul_comb #(.W(H)) u_lo (
      .i_a(i_a[H-1:0]), .i_b(i_b[H-1:0]), .o_p(w_l)
    );
    karatsuba_clmul_comb #(.W(H)) u_hi (
      .i_a(i_a[W-1:H]), .i_b(i_b[W-1:H]), .o_p(w_h)
    );
    karatsuba_clmul_comb #(.W(H)) u_mid (
      .i_a(i_a[H-1:0] ^ i_a[W-1:H]), .i_b(i_b[H-1:0] ^ i_b[W-1:H]), .o_p(w_m)
    );

    assign o_p = {w_h, w_l} ^ ({{W{1'b0}}, w_m ^ w_l ^ w_h} << H);
  end

endmodule

// File: rtl/karatsuba_clmul_seq.sv
// Multi-cycle carry-less multiplier: one Karatsuba split over a shared half-width core,
// optional reduction modulo x^WIDTH + POLY, valid/ready on both sides.
module karatsuba_clmul_seq
  import karatsuba_pkg::*;
#(
  parameter int unsigned       WIDTH = 16,
  parameter logic [WIDTH-1:0]  POLY  = POLY_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic                 in_reduce,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_p
);

  localparam int unsigned H = WIDTH / 2;

  state_t               r_state, w_next;
  logic [WIDTH-1:0]     r_a, r_b, r_l, r_h, r_m;
  logic                 r_red;
  logic [2*WIDTH-1:0]   r_p, w_comb, w_red;
  logic [H-1:0]         w_ca, w_cb;
  logic [WIDTH-1:0]     w_core;
  logic                 w_in_xfer, w_out_xfer;

  assign in_ready   = (r_state == IDLE) && !rst;
  assign out_valid  = (r_state == DONE);
  assign out_p      = r_p;
  assign w_in_xfer  = in_valid && in_ready;
  assign w_out_xfer = out_valid && out_ready;

  always_comb begin
    w_ca = r_a[H-1:0] ^ r_a[WIDTH-1:H];
    w_cb = r_b[H-1:0] ^ r_b[WIDTH-1:H];
    case (r_state)
      M_LO: begin w_ca = r_a[H-1:0];     w_cb = r_b[H-1:0];     end
      M_HI: begin w_ca = r_a[WIDTH-1:H]; w_cb = r_b[WIDTH-1:H]; end
      default: ;
    endcase
  end

  karatsuba_clmul_comb #(.W(H)) u_core (
    .i_a(w_ca), .i_b(w_cb), .o_p(w_core)
  );

  assign w_comb = {r_h, r_l} ^ ({{WIDTH{1'b0}}, r_m ^ r_l ^ r_h} << H);

  // Fold high bits from the top down so bits spilled by POLY below x^WIDTH are caught in the same pass.
  always_comb begin : p_reduce
    logic [2*WIDTH-1:0] t;
    t = r_p;
    for (int unsigned k = 0; k < WIDTH; k++) begin
      if (t[2*WIDTH-1-k]) begin
        t[2*WIDTH-1-k] = 1'b0;
        t[WIDTH-1-k +: WIDTH] = t[WIDTH-1-k +: WIDTH] ^ POLY;
      end
    end
    w_red = {{WIDTH{1'b0}}, t[WIDTH-1:0]};
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_in_xfer) w_next = M_LO;
      M_LO:    w_next = M_HI;
      M_HI:    w_next = M_MID;
      M_MID:   w_next = COMBINE;
      COMBINE: w_next = r_red ? REDUCE : DONE;
      REDUCE:  w_next = DONE;
      DONE:    if (w_out_xfer) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_red   <= 1'b0;
      r_l     <= '0;
      r_h     <= '0;
      r_m     <= '0;
      r_p     <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: if (w_in_xfer) begin
          r_a   <= in_a;
          r_b   <= in_b;
          r_red <= in_reduce;
        end
        M_LO:    r_l <= w_core;
        M_HI:    r_h <= w_core;
        M_MID:   r_m <= w_core;
        COMBINE: r_p <= w_comb;
        REDUCE:  r_p <= w_red;
        default: ;
      endcase
    end
  end

endmodule
